zero_cross: RTL and testbench
=============================

# zero_cross

Signed-sample zero-crossing detector with hysteresis and post-crossing holdoff. It sits after the sample-rate pulse-processing datapath (e.g. downstream of the ACC1632 accumulator/shaper chain). It emits a one-cycle pulse on `outP` when the signal crosses from negative to positive and on `outN` when it crosses from positive to negative.

## Interface
Parameters:
- `WIDTH`, default 16: sample width, two's complement.
- `HYST`, default 64: hysteresis threshold magnitude. Must satisfy 0 ≤ `HYST` < 2^(`WIDTH`-1).
- `HOLDOFF`, default 4: cycles after an accepted crossing during which no state change is allowed. 0 disables holdoff.

Ports:
- `clk`  input  1: single clock, rising-edge.
- `clr`  input  1: reset, asynchronous, active-low.
- `X`  input  `WIDTH` signed: one sample per clock.
- `outP`  output  1: registered; one-cycle pulse on a negative→positive crossing.
- `outN`  output  1: registered; one-cycle pulse on a positive→negative crossing.

## Operation
- State machine with three states: UNK (polarity unknown), POS, NEG.
- Thresholds are compared signed, with `X` sign-extended to `WIDTH`+1 bits so there is no overflow at the extremes.
  - TH_P: `X` > +`HYST`.
  - TH_N: `X` < −`HYST`.
- Transitions, evaluated at each rising edge on the current `X`:
  - UNK → POS on TH_P; UNK → NEG on TH_N. No pulse on either.
  - NEG → POS on TH_P: `outP`=1 next cycle; holdoff counter loaded with `HOLDOFF`.
  - POS → NEG on TH_N: `outN`=1 next cycle; holdoff counter loaded with `HOLDOFF`.
  - All other cases: state unchanged.
  - Samples inside the band [−`HYST`, +`HYST`] never change state, including `X`=0.
- Holdoff:
  - While the counter is nonzero it decrements each cycle and all transitions are blocked.
  - A threshold condition that still holds when the counter reaches 0 is accepted on that cycle. The crossing is delayed, not lost.
- `outP` and `outN` are never 1 in the same cycle. Each is high for exactly one cycle per accepted crossing.
- Reset (`clr`=0, at any time, including mid-pulse or mid-holdoff):
  - state=UNK, holdoff counter=0, `outP`=0, `outN`=0.
  - Takes effect immediately, with no clock required.
- Release (`clr`=1) is used synchronously. The first edge after release evaluates `X` normally from UNK.

## Timing
- Latency: a qualifying `X` sampled at edge k gives a pulse high from edge k until edge k+1.
- Minimum spacing between two pulses is `HOLDOFF`+1 cycles. For `HOLDOFF`=0 it is 1 cycle, so alternating ±large samples give `outP`/`outN` on consecutive cycles.
- Reset values: `outP`=0, `outN`=0.
- There is no input handshake; `X` is consumed every cycle.

## Configuration
- Macro `ZERO_CROSS_HYST_EN`.
- Defined: thresholds are ±`HYST` as described above.
- Undefined: `HYST` is ignored and treated as 0.
  - TH_P is `X` > 0 and TH_N is `X` < 0.
  - `X`=0 still holds state.
  - All other behaviour (holdoff, pulses, reset) is identical.

## Test plan
All scenarios use default parameters with `ZERO_CROSS_HYST_EN` defined unless stated.
1. Reset and idle:
   - Stimulus: `clr`=0 for 4 cycles, then `clr`=1 with `X`=0 for 8 cycles.
   - Required: `outP`=`outN`=0 throughout; state stays UNK.
2. Descending ramp:
   - Stimulus: `X`=1000, decaying by /1.01 for 10 samples (≈905), then −101 per cycle for 30 samples.
   - Required: no pulse on the first entry to POS.
   - Required: exactly one `outN`, one cycle after the first sample < −64 (≈−105). No `outP`.
3. Ascending ramp:
   - Stimulus: continue from scenario 2 (≈−2125), +201 per cycle for 20 samples.
   - Required: exactly one `outP`, one cycle after the first sample > 64.
4. Hysteresis band:
   - Stimulus: from POS, `X` alternating +50/−50 for 20 cycles.
   - Required: no pulses.
   - Rebuild with `ZERO_CROSS_HYST_EN` undefined, same stimulus. Required: `outN` on the first −50, then none until holdoff expires, after which pulses alternate at a spacing of 5 cycles.
5. Holdoff:
   - Stimulus: from NEG, `X`=+1000, then −1000 held.
   - Required: `outP` at cycle 1; `outN` at cycle 6 (delayed by `HOLDOFF`, not lost).
6. Asynchronous reset mid-pulse:
   - Stimulus: assert `clr`=0 between clock edges while `outN`=1.
   - Required: `outN` drops immediately.
   - Required: after release with `X`=−1000, no `outN` (entry from UNK).

Source files
------------

// File: rtl/zero_cross.sv
// Signed-sample zero-crossing detector with hysteresis and post-crossing holdoff.
// Optional macro ZERO_CROSS_HYST_EN: when undefined, HYST is ignored (thresholds at zero).
module zero_cross #(
    parameter int WIDTH   = 16,
    parameter int HYST    = 64,
    parameter int HOLDOFF = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic signed [WIDTH-1:0] X,
    output logic                    outP,
    output logic                    outN
);

`ifdef ZERO_CROSS_HYST_EN
    localparam bit L_HYST_EN = 1'b1;
`else
    localparam bit L_HYST_EN = 1'b0;
`endif

    localparam logic signed [WIDTH:0] L_HYST_P = L_HYST_EN ? (WIDTH + 1)'(HYST) : '0;
    localparam logic signed [WIDTH:0] L_HYST_N = -L_HYST_P;

    localparam int             CW     = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [CW-1:0]  L_HOLD = CW'(HOLDOFF);
    localparam logic [CW-1:0]  L_ONE  = CW'(1);
    localparam logic [CW-1:0]  L_ZERO = CW'(0);

    typedef enum logic [1:0] {
        ST_UNK = 2'd0,
        ST_POS = 2'd1,
        ST_NEG = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   r_outp;
    logic                   r_outn;
    logic                   w_outp_nxt;
    logic                   w_outn_nxt;
    logic signed [WIDTH:0]  w_x_ext;
    logic                   w_th_p;
    logic                   w_th_n;

    // Extra sign bit keeps the comparison exact at the most negative sample.
    assign w_x_ext = {X[WIDTH-1], X};
    assign w_th_p  = (w_x_ext > L_HYST_P);
    assign w_th_n  = (w_x_ext < L_HYST_N);

    // State, holdoff counter and pulse registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_UNK;
            r_cnt   <= L_ZERO;
            r_outp  <= 1'b0;
            r_outn  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_outp  <= w_outp_nxt;
            r_outn  <= w_outn_nxt;
        end
    end

    // Next-state logic; a running holdoff freezes polarity so a crossing is only delayed.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_outp_nxt  = 1'b0;
        w_outn_nxt  = 1'b0;
        if (r_cnt != L_ZERO) begin
            w_cnt_nxt = r_cnt - L_ONE;
        end else begin
            case (r_state)
                ST_UNK: begin
                    if (w_th_p) begin
                        w_state_nxt = ST_POS;
                    end else if (w_th_n) begin
                        w_state_nxt = ST_NEG;
                    end else begin
                        w_state_nxt = ST_UNK;
                    end
                end
                ST_NEG: begin
                    if (w_th_p) begin
                        w_state_nxt = ST_POS;
                        w_outp_nxt  = 1'b1;
                        w_cnt_nxt   = L_HOLD;
                    end else begin
                        w_state_nxt = ST_NEG;
                    end
                end
                ST_POS: begin
                    if (w_th_n) begin
                        w_state_nxt = ST_NEG;
                        w_outn_nxt  = 1'b1;
                        w_cnt_nxt   = L_HOLD;
                    end else begin
                        w_state_nxt = ST_POS;
                    end
                end
                default: begin
                    w_state_nxt = ST_UNK;
                    w_cnt_nxt   = L_ZERO;
                end
            endcase
        end
    end

    assign outP = r_outp;
    assign outN = r_outn;

endmodule

// File: tb/tb_zero_cross.sv
// Randomized bench for zero_cross against a polarity/timestamp reference model.
module tb_zero_cross;

    localparam int WIDTH   = 16;
    localparam int HYST    = 64;
    localparam int HOLDOFF = 4;
`ifdef ZERO_CROSS_HYST_EN
    localparam int M_H = HYST;
`else
    localparam int M_H = 0;
`endif

    logic                    clk;
    logic                    clr;
    logic signed [WIDTH-1:0] X;
    logic                    outP;
    logic                    outN;

    int n_total;
    int n_bad;
    int cnt_p;
    int cnt_n;

    // Reference model: polarity as -1/0/+1, holdoff as distance from last accepted edge.
    int m_pol;
    int m_t;
    int m_last;

    zero_cross #(.WIDTH(WIDTH), .HYST(HYST), .HOLDOFF(HOLDOFF)) dut (
        .clk  (clk),
        .clr  (clr),
        .X    (X),
        .outP (outP),
        .outN (outN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pol  = 0;
        m_t    = 0;
        m_last = -100000;
    endtask

    task automatic model_edge(input int v, output bit ep, output bit en);
        bit thp;
        bit thn;
        thp = (v > M_H);
        thn = (v < -M_H);
        ep  = 1'b0;
        en  = 1'b0;
        if ((m_t - m_last) > HOLDOFF) begin
            if (m_pol == 0) begin
                if (thp) m_pol = 1;
                else if (thn) m_pol = -1;
            end else if (m_pol < 0 && thp) begin
                m_pol = 1; ep = 1'b1; m_last = m_t;
            end else if (m_pol > 0 && thn) begin
                m_pol = -1; en = 1'b1; m_last = m_t;
            end
        end
        m_t++;
    endtask

    // Drive one sample, let one edge consume it, then check the registered pulses.
    task automatic step(input string tag, input int v);
        bit ep;
        bit en;
        X = WIDTH'(v);
        model_edge(v, ep, en);
        @(posedge clk);
        #1;
        check_val({tag, "_outP"}, 32'(outP), 32'(ep));
        check_val({tag, "_outN"}, 32'(outN), 32'(en));
        if (outP) cnt_p++;
        if (outN) cnt_n++;
    endtask

    // Assert clr between edges, hold through one edge, release just after the next edge.
    task automatic async_reset(input string tag);
        #2;
        clr = 1'b0;
        model_reset();
        #1;
        check_val({tag, "_async_outP"}, 32'(outP), 32'd0);
        check_val({tag, "_async_outN"}, 32'(outN), 32'd0);
        @(posedge clk);
        #1;
        check_val({tag, "_held_outP"}, 32'(outP), 32'd0);
        check_val({tag, "_held_outN"}, 32'(outN), 32'd0);
        clr = 1'b1;
    endtask

    function automatic int rand_x();
        int c;
        int mag;
        int edges [7];
        c = int'($urandom_range(0, 9));
        edges = '{M_H, -M_H, M_H + 1, -M_H - 1, 32767, -32768, 0};
        if (c < 4) begin
            mag = int'($urandom_range(M_H + 1, 32767));
            return ($urandom_range(0, 1) == 0) ? mag : -mag;
        end else if (c < 8) begin
            return int'($urandom_range(0, 2 * M_H)) - M_H;
        end else begin
            return edges[$urandom_range(0, 6)];
        end
    endfunction

    initial begin
        real r;
        n_total = 0;
        n_bad   = 0;
        cnt_p   = 0;
        cnt_n   = 0;
        model_reset();
        clr = 1'b0;
        X   = '0;

        // Reset and idle
        #1;
        check_val("rst0_outP", 32'(outP), 32'd0);
        check_val("rst0_outN", 32'(outN), 32'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
            check_val("rst_outP", 32'(outP), 32'd0);
            check_val("rst_outN", 32'(outN), 32'd0);
        end
        clr = 1'b1;
        for (int i = 0; i < 8; i++) step("idle", 0);

        // Descending ramp: entry to POS silent, one outN
        cnt_p = 0;
        cnt_n = 0;
        r = 1000.0;
        for (int i = 0; i < 10; i++) begin
            step("desc", $rtoi(r));
            r = r / 1.01;
        end
        for (int i = 1; i <= 30; i++) step("desc", 905 - 101 * i);
        check_val("desc_n_count", 32'(cnt_n), 32'd1);
        check_val("desc_p_count", 32'(cnt_p), 32'd0);

        // Ascending ramp: one outP
        cnt_p = 0;
        cnt_n = 0;
        for (int i = 1; i <= 20; i++) step("asc", -2125 + 201 * i);
        check_val("asc_p_count", 32'(cnt_p), 32'd1);
        check_val("asc_n_count", 32'(cnt_n), 32'd0);

        // Hysteresis band from POS
        cnt_p = 0;
        cnt_n = 0;
        for (int i = 0; i < 20; i++) step("band", (i % 2 == 0) ? 50 : -50);
`ifdef ZERO_CROSS_HYST_EN
        check_val("band_pulses", 32'(cnt_p + cnt_n), 32'd0);
`else
        check_val("band_pulses", 32'(cnt_p + cnt_n), 32'd4);
`endif

        // Holdoff: outN delayed by HOLDOFF, not lost
        for (int i = 0; i < 8; i++) step("ho_pre", -1000);
        step("ho_p", 1000);
        for (int i = 0; i < 8; i++) step("ho_n", -1000);

        // Asynchronous reset while outN is high
        for (int i = 0; i < 6; i++) step("ar_pre", 1000);
        step("ar_pulse", -1000);
        check_val("ar_outN_high", 32'(outN), 32'd1);
        async_reset("ar");
        for (int i = 0; i < 4; i++) step("ar_post", -1000);

        // Randomized stimulus with occasional mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            step("rnd", rand_x());
            if ($urandom_range(0, 99) == 0) async_reset("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
